// File: rtl/pos_pkt_arbiter_pkg.sv
// rtl/pos_pkt_arbiter_pkg.sv - shared types and constants for the position packet arbiter
// Purpose: packet/GCID widths, FIFO entry layout, FSM state encoding.
package pos_pkt_arbiter_pkg;

  localparam int OFFSET_PKT_STRUCT_WIDTH = 8;
  localparam int GLOBAL_CELL_ID_WIDTH    = 4;
  localparam int POS_ARB_FIFO_DEPTH      = 16;
  localparam int POS_ARB_PKT_W           = OFFSET_PKT_STRUCT_WIDTH;
  localparam int POS_ARB_GCID_W          = 3 * GLOBAL_CELL_ID_WIDTH;

  // GCID sits above the packet so the packed entry is {gcid, pkt}
  typedef struct packed {
    logic [POS_ARB_GCID_W-1:0] gcid;
    logic [POS_ARB_PKT_W-1:0]  pkt;
  } pos_arb_entry_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_DRAIN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pos_pkt_fifo.sv
// rtl/pos_pkt_fifo.sv - per-cell synchronous FIFO of {gcid, pkt} entries
// Purpose: buffers one cell's packets in arrival order.
// Ports: clk, rst (async high), i_push/i_data write side, i_pop/o_data read side
//        (o_data is the head entry, valid while !o_empty), o_empty, o_full, o_count.
module pos_pkt_fifo
  import pos_pkt_arbiter_pkg::*;
#(
  parameter int DATA_W = $bits(pos_arb_entry_t),
  parameter int DEPTH  = POS_ARB_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // Full/empty come from registered occupancy, so a push is judged before any same-cycle pop
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/pos_pkt_arbiter.sv
// rtl/pos_pkt_arbiter.sv - per-cell FIFOs, round-robin arbiter and output register feeding the PE
// Purpose: buffer each cell's {gcid, pkt}, arbitrate cells round-robin onto one valid/ready
//          stream, and sequence IDLE -> ACTIVE -> DRAIN -> IDLE with a drain-complete pulse.
// Config:  POS_PKT_ARB_STATS_EN builds per-cell sent counters; otherwise o_sent_cnt is 0.
// Ports:   clk, rst (async high); i_PE_start / i_MU_start phase pulses;
//          i_pos_pkt / i_cur_gcid / i_valid per-cell inputs; o_almost_full, o_overflow per cell;
//          o_pkt / o_gcid / o_src_cell / o_pkt_valid with i_pkt_ready output stream;
//          o_drained pulse, o_state debug, o_sent_cnt per-cell 16-bit handshake counts.
module pos_pkt_arbiter
  import pos_pkt_arbiter_pkg::*;
#(
  parameter int NUM_CELLS  = 8,
  parameter int PKT_W      = POS_ARB_PKT_W,
  parameter int GCID_W     = POS_ARB_GCID_W,
  parameter int FIFO_DEPTH = POS_ARB_FIFO_DEPTH,
  parameter int AFULL_LVL  = FIFO_DEPTH - 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_PE_start,
  input  logic                          i_MU_start,
  input  logic [NUM_CELLS*PKT_W-1:0]    i_pos_pkt,
  input  logic [NUM_CELLS*GCID_W-1:0]   i_cur_gcid,
  input  logic [NUM_CELLS-1:0]          i_valid,
  output logic [NUM_CELLS-1:0]          o_almost_full,
  output logic [NUM_CELLS-1:0]          o_overflow,
  output logic [PKT_W-1:0]              o_pkt,
  output logic [GCID_W-1:0]             o_gcid,
  output logic [$clog2(NUM_CELLS)-1:0]  o_src_cell,
  output logic                          o_pkt_valid,
  input  logic                          i_pkt_ready,
  output logic                          o_drained,
  output logic [1:0]                    o_state,
  output logic [NUM_CELLS*16-1:0]       o_sent_cnt
);

  localparam int SRC_W = $clog2(NUM_CELLS);
  localparam int ENT_W = PKT_W + GCID_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_drained;
  logic              w_accept;

  logic [NUM_CELLS-1:0] w_empty;
  logic [NUM_CELLS-1:0] w_full;
  logic [NUM_CELLS-1:0] w_push;
  logic [NUM_CELLS-1:0] w_pop;
  logic [ENT_W-1:0]     w_fifo_dout [NUM_CELLS];
  logic [CNT_W-1:0]     w_count     [NUM_CELLS];
  logic [NUM_CELLS-1:0] r_ovf;

  logic [SRC_W-1:0]  r_rr;
  logic [SRC_W-1:0]  w_grant;
  logic [SRC_W-1:0]  w_idx;
  logic              w_grant_valid;
  logic              w_load;

  logic              r_valid;
  logic [ENT_W-1:0]  r_data;
  logic [SRC_W-1:0]  r_src;

  assign w_accept = (r_state != ARB_IDLE);
  // Output register takes a new entry whenever it is empty or its entry leaves this cycle
  assign w_load   = ~r_valid | i_pkt_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_CELLS; g++) begin : g_cell
      assign w_push[g] = i_valid[g] & w_accept & ~w_full[g];
      assign w_pop[g]  = w_load & w_grant_valid & (w_grant == SRC_W'(g));
      assign o_almost_full[g] = (w_count[g] >= CNT_W'(AFULL_LVL));

      pos_pkt_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[g]),
        .i_data  ({i_cur_gcid[g*GCID_W +: GCID_W], i_pos_pkt[g*PKT_W +: PKT_W]}),
        .i_pop   (w_pop[g]),
        .o_data  (w_fifo_dout[g]),
        .o_empty (w_empty[g]),
        .o_full  (w_full[g]),
        .o_count (w_count[g])
      );
    end
  endgenerate

  // First non-empty FIFO at or after the round-robin pointer
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_idx         = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      w_idx = SRC_W'((int'(r_rr) + i) % NUM_CELLS);
      if (!w_grant_valid && !w_empty[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant       = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_rr    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ovf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_valid <= w_grant_valid;
        if (w_grant_valid) begin
          r_data <= w_fifo_dout[w_grant];
          r_src  <= w_grant;
          r_rr   <= (w_grant == SRC_W'(NUM_CELLS-1)) ? '0 : w_grant + 1'b1;
        end
      end
      if (i_PE_start) r_ovf <= '0;
      else            r_ovf <= r_ovf | (i_valid & w_full & {NUM_CELLS{w_accept}});
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drained   = 1'b0;
    case (r_state)
      ARB_IDLE:   if (i_PE_start) w_state_nxt = ARB_ACTIVE;
      ARB_ACTIVE: if (i_MU_start) w_state_nxt = ARB_DRAIN;
      ARB_DRAIN: begin
        if ((&w_empty) && !r_valid) begin
          w_state_nxt = ARB_IDLE;
          w_drained   = 1'b1;
        end
      end
      default:    w_state_nxt = ARB_IDLE;
    endcase
  end

  assign o_pkt       = r_data[PKT_W-1:0];
  assign o_gcid      = r_data[PKT_W +: GCID_W];
  assign o_src_cell  = r_src;
  assign o_pkt_valid = r_valid;
  assign o_overflow  = r_ovf;
  assign o_drained   = w_drained;
  assign o_state     = r_state;

`ifdef POS_PKT_ARB_STATS_EN
  generate
    for (g = 0; g < NUM_CELLS; g++) begin : g_stats
      logic [15:0] r_sent;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sent <= '0;
        end else if (i_PE_start) begin
          r_sent <= '0;
        end else if (r_valid && i_pkt_ready && (r_src == SRC_W'(g)) && (r_sent != 16'hFFFF)) begin
          r_sent <= r_sent + 16'd1;
        end
      end
      assign o_sent_cnt[g*16 +: 16] = r_sent;
    end
  endgenerate
`else
  assign o_sent_cnt = '0;
`endif

endmodule

// File: tb/tb_pos_pkt_arbiter.sv
// tb/tb_pos_pkt_arbiter.sv - scoreboard bench for pos_pkt_arbiter
module tb_pos_pkt_arbiter;
  import pos_pkt_arbiter_pkg::*;

  localparam int N  = 8;
  localparam int PW = POS_ARB_PKT_W;
  localparam int GW = POS_ARB_GCID_W;
  localparam int SW = 3;
  localparam int EW = SW + GW + PW;

  logic            clk;
  logic            rst;
  logic            i_PE_start;
  logic            i_MU_start;
  logic [N*PW-1:0] i_pos_pkt;
  logic [N*GW-1:0] i_cur_gcid;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    o_almost_full;
  logic [N-1:0]    o_overflow;
  logic [PW-1:0]   o_pkt;
  logic [GW-1:0]   o_gcid;
  logic [SW-1:0]   o_src_cell;
  logic            o_pkt_valid;
  logic            i_pkt_ready;
  logic            o_drained;
  logic [1:0]      o_state;
  logic [N*16-1:0] o_sent_cnt;

  pos_pkt_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_PE_start    (i_PE_start),
    .i_MU_start    (i_MU_start),
    .i_pos_pkt     (i_pos_pkt),
    .i_cur_gcid    (i_cur_gcid),
    .i_valid       (i_valid),
    .o_almost_full (o_almost_full),
    .o_overflow    (o_overflow),
    .o_pkt         (o_pkt),
    .o_gcid        (o_gcid),
    .o_src_cell    (o_src_cell),
    .o_pkt_valid   (o_pkt_valid),
    .i_pkt_ready   (i_pkt_ready),
    .o_drained     (o_drained),
    .o_state       (o_state),
    .o_sent_cnt    (o_sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_drained = 0;
  logic          hold_v = 1'b0;
  logic [EW-1:0] hold_d = '0;
  logic [15:0]   exp_sent;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive cells in mask for one cycle; lane c carries pb+c / gb+c. Expected entries are
  // queued in ascending cell order, which callers use only where the RR pointer makes it so.
  task automatic push(input logic [N-1:0] mask, input logic [PW-1:0] pb,
                      input logic [GW-1:0] gb, input bit enq);
    logic [PW-1:0] p;
    logic [GW-1:0] gc;
    logic [SW-1:0] s;
    for (int c = 0; c < N; c++) begin
      if (mask[c]) begin
        p  = pb + PW'(c);
        gc = gb + GW'(c);
        s  = SW'(c);
        i_pos_pkt[c*PW +: PW]  = p;
        i_cur_gcid[c*GW +: GW] = gc;
        if (enq) sb.push_back({s, gc, p});
      end
    end
    i_valid = mask;
    tick();
    i_valid = '0;
  endtask

  task automatic pulse_pe;
    i_PE_start = 1'b1;
    tick();
    i_PE_start = 1'b0;
  endtask

  task automatic pulse_mu;
    i_MU_start = 1'b1;
    tick();
    i_MU_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int k;
    k = 0;
    while ((sb.size() != 0 || o_pkt_valid) && k < bound) begin
      tick();
      k++;
    end
    chk(nm, 64'(k < bound), 64'd1);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", 64'(o_pkt_valid), 64'd1);
        chk("stall_data", 64'({o_src_cell, o_gcid, o_pkt}), 64'(hold_d));
      end
      if (o_drained) n_drained++;
      if (o_pkt_valid && i_pkt_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'({o_src_cell, o_gcid, o_pkt}), 64'hDEAD_0000_0000);
        end else begin
          chk("out_entry", 64'({o_src_cell, o_gcid, o_pkt}), 64'(sb.pop_front()));
        end
      end
      hold_v = o_pkt_valid && !i_pkt_ready;
      hold_d = {o_src_cell, o_gcid, o_pkt};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_PE_start = 1'b0; i_MU_start = 1'b0;
    i_pos_pkt = '0; i_cur_gcid = '0; i_valid = '0; i_pkt_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 64'(o_pkt_valid), 64'd0);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_afull", 64'(o_almost_full), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_drained", 64'(o_drained), 64'd0);
    chk("rst_sent", 64'(o_sent_cnt[63:0]), 64'd0);
    rst = 1'b0;
    tick();

    // 1: single packet on cell 3, one-cycle latency
    pulse_pe();
    chk("t1_state_active", 64'(o_state), 64'd1);
    i_pos_pkt[3*PW +: PW] = 8'hA5;
    i_cur_gcid[3*GW +: GW] = 12'h123;
    sb.push_back({3'd3, 12'h123, 8'hA5});
    i_valid = 8'h08;
    tick();
    i_valid = '0;
    chk("t1_no_cut_through", 64'(o_pkt_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(o_pkt_valid), 64'd1);
    chk("t1_src", 64'(o_src_cell), 64'd3);
    chk("t1_pkt", 64'(o_pkt), 64'hA5);
    chk("t1_gcid", 64'(o_gcid), 64'h123);
    wait_idle("t1_drain", 20);

    // 2: fresh RR pointer, all cells at once -> 0..7, then cells 2,5
    rst = 1'b1; tick(); rst = 1'b0; tick();
    pulse_pe();
    push(8'hFF, 8'h10, 12'h200, 1'b1);
    wait_idle("t2_all", 40);
    push(8'h24, 8'h40, 12'h240, 1'b1);
    wait_idle("t2_pair", 20);

    // 3: stalled output; first packet moves to the output register, so the FIFO holds
    // pushes 2..17: 12 entries after the 13th push, full after the 17th, 18th dropped
    i_pkt_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      push(8'h01, PW'(8'h30 + k), GW'(12'h300 + k), k < 17);
      if (k == 11) chk("t3_afull_below", 64'(o_almost_full), 64'h00);
      if (k == 12) chk("t3_afull_rise", 64'(o_almost_full), 64'h01);
      if (k == 16) chk("t3_ovf_before", 64'(o_overflow), 64'h00);
      if (k == 17) chk("t3_ovf_set", 64'(o_overflow), 64'h01);
    end
    i_pkt_ready = 1'b1;
    wait_idle("t3_release", 60);

    // 4: ready toggles every cycle while cell 1 streams
    fork
      begin
        for (int k = 0; k < 12; k++) push(8'h02, PW'(8'h60 + k), GW'(12'h600 + k), 1'b1);
      end
      begin
        repeat (30) begin
          tick();
          i_pkt_ready = ~i_pkt_ready;
        end
      end
    join
    i_pkt_ready = 1'b1;
    wait_idle("t4_stream", 60);

    // 5: 5 queued packets, then drain
    n_drained = 0;
    i_pkt_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(8'h04, PW'(8'h80 + k), GW'(12'h500 + k), 1'b1);
    pulse_mu();
    chk("t5_state_drain", 64'(o_state), 64'd2);
    i_pkt_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (o_state != 2'd0 && k < 50) begin
        tick();
        k++;
      end
      chk("t5_reach_idle", 64'(k < 50), 64'd1);
    end
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
    chk("t5_drained_once", 64'(n_drained), 64'd1);
    chk("t5_state_idle", 64'(o_state), 64'd0);
    for (int k = 0; k < 3; k++) push(8'hFF, 8'hC0, 12'hC00, 1'b0);
    repeat (3) tick();
    chk("t5_idle_ignored", 64'(o_pkt_valid), 64'd0);
    chk("t5_idle_ovf", 64'(o_overflow), 64'h01);
    chk("t5_idle_afull", 64'(o_almost_full), 64'h00);
    chk("t5_drained_total", 64'(n_drained), 64'd1);

    // 6: stats, then async reset mid-stream
    pulse_pe();
    chk("t6_ovf_cleared", 64'(o_overflow), 64'h00);
    for (int k = 0; k < 3; k++) push(8'h10, PW'(8'hD0 + k), GW'(12'hD00 + k), 1'b1);
    wait_idle("t6_pre", 20);
`ifdef POS_PKT_ARB_STATS_EN
    exp_sent = 16'd3;
`else
    exp_sent = 16'd0;
`endif
    chk("t6_sent_cnt", 64'(o_sent_cnt[4*16 +: 16]), 64'(exp_sent));
    i_pkt_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(8'h10, PW'(8'hE0 + k), GW'(12'hE00 + k), 1'b1);
    chk("t6_stalled_valid", 64'(o_pkt_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(o_pkt_valid), 64'd0);
    chk("t6_rst_afull", 64'(o_almost_full), 64'h00);
    chk("t6_rst_state", 64'(o_state), 64'd0);
    chk("t6_rst_sent", 64'(o_sent_cnt[4*16 +: 16]), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    i_pkt_ready = 1'b1;
    repeat (10) tick();
    chk("t6_fifos_empty", 64'(o_pkt_valid), 64'd0);
    pulse_pe();
    for (int k = 0; k < 2; k++) push(8'h10, PW'(8'hF0 + k), GW'(12'hF00 + k), 1'b1);
    wait_idle("t6_post", 20);
`ifdef POS_PKT_ARB_STATS_EN
    exp_sent = 16'd2;
`else
    exp_sent = 16'd0;
`endif
    chk("t6_sent_after_rst", 64'(o_sent_cnt[4*16 +: 16]), 64'(exp_sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
